score_digit_ctrl: RTL and testbench

SCORE_DIGIT_CTRL -- requirements
Module: score_digit_ctrl

---
 rtl/score_digit_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_score_digit_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_ctrl.sv
// Score digit controller: accepts a binary score, converts it to four BCD
// digits with a serial shift-add-3 engine, commits the digits to the display
// only on a frame boundary, and maps each pixel coordinate to the digit slot
// under it with leading-zero blanking.
module score_digit_ctrl #(
   parameter logic [31:0] BASE_X = 32'd20,
   parameter logic [31:0] BASE_Y = 32'd20,
   parameter logic [31:0] PITCH  = 32'd60
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [13:0] score,
   input  logic        score_valid,
   output logic        score_ready,
   input  logic        frame_start,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic [3:0]  digit_num,
   output logic [31:0] digit_sx,
   output logic [31:0] digit_sy,
   output logic        digit_en,
   output logic        ovf
);

   localparam logic [13:0] MAX_SCORE = 14'd9999;
   localparam logic [3:0]  LAST_STEP = 4'd13;  // 14 conversion steps: 0..13
   localparam logic [31:0] SLOT_W    = 32'd50;
   localparam logic [31:0] SLOT_H    = 32'd90;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      PENDING
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        load;
   logic        step;
   logic        commit;

   logic [13:0] bin_sr;    // binary bits still to be shifted into the BCD side
   logic [15:0] bcd;       // conversion result, thousands in [15:12]
   logic [3:0]  step_cnt;
   logic [29:0] dd_nxt;    // {bcd, bin_sr} after one adjust-and-shift step
   logic [3:0]  disp [4];  // displayed digits, index 0 = thousands

   logic [31:0] slot_sx [4];
   logic [3:0]  in_slot;
   logic [3:0]  blank;
   logic        in_rows;

   logic [3:0]  num_nxt;
   logic [31:0] sx_nxt;
   logic        en_nxt;

   // A BCD nibble of 5 or more is bumped by 3 so the following shift carries
   // correctly into the next decimal digit.
   function automatic logic [3:0] nib_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   assign dd_nxt = {nib_adj(bcd[15:12]), nib_adj(bcd[11:8]),
                    nib_adj(bcd[7:4]),   nib_adj(bcd[3:0]), bin_sr} << 1;

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and control strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      score_ready = 1'b0;
      load        = 1'b0;
      step        = 1'b0;
      commit      = 1'b0;
      unique case (state)
         IDLE: begin
            score_ready = 1'b1;
            if (score_valid) begin
               load      = 1'b1;
               state_nxt = CONVERT;
            end
         end
         CONVERT: begin
            step = 1'b1;
            if (step_cnt == LAST_STEP) state_nxt = PENDING;
         end
         PENDING: begin
            if (frame_start) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Score capture, serial conversion and atomic display commit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bin_sr   <= '0;
         bcd      <= '0;
         step_cnt <= '0;
         ovf      <= 1'b0;
         // NOTE: the display array is only four registers and must read 0000
         // out of reset, so it is reset like any other flop.
         for (int i = 0; i < 4; i++) disp[i] <= '0;
      end else begin
         if (load) begin
            bin_sr   <= (score > MAX_SCORE) ? MAX_SCORE : score;
            bcd      <= '0;
            step_cnt <= '0;
            ovf      <= (score > MAX_SCORE);
         end else if (step) begin
            bcd      <= dd_nxt[29:14];
            bin_sr   <= dd_nxt[13:0];
            step_cnt <= step_cnt + 4'd1;
         end
         if (commit) begin
            disp[0] <= bcd[15:12];
            disp[1] <= bcd[11:8];
            disp[2] <= bcd[7:4];
            disp[3] <= bcd[3:0];
         end
      end
   end

   // Slot geometry: half-open boxes, all arithmetic in 32-bit unsigned.
   assign in_rows = (y >= BASE_Y) && (y < BASE_Y + SLOT_H);

   for (genvar k = 0; k < 4; k++) begin : g_slot
      assign slot_sx[k] = BASE_X + PITCH * 32'(k);
      assign in_slot[k] = in_rows && (x >= slot_sx[k]) && (x < slot_sx[k] + SLOT_W);
   end

   // A slot is blanked when it and every more-significant digit are zero;
   // the units slot always shows.
   assign blank[0] = (disp[0] == 4'd0);
   assign blank[1] = blank[0] && (disp[1] == 4'd0);
   assign blank[2] = blank[1] && (disp[2] == 4'd0);
   assign blank[3] = 1'b0;

   // Select the slot under the current pixel.
   always_comb begin
      num_nxt = 4'd0;
      sx_nxt  = BASE_X;
      en_nxt  = 1'b0;
      if (in_slot[0]) begin
         num_nxt = disp[0];
         sx_nxt  = slot_sx[0];
         en_nxt  = !blank[0];
      end else if (in_slot[1]) begin
         num_nxt = disp[1];
         sx_nxt  = slot_sx[1];
         en_nxt  = !blank[1];
      end else if (in_slot[2]) begin
         num_nxt = disp[2];
         sx_nxt  = slot_sx[2];
         en_nxt  = !blank[2];
      end else if (in_slot[3]) begin
         num_nxt = disp[3];
         sx_nxt  = slot_sx[3];
         en_nxt  = !blank[3];
      end
   end

   // Pixel outputs, registered one cycle after x/y.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         digit_num <= 4'd0;
         digit_sx  <= BASE_X;
         digit_sy  <= BASE_Y;
         digit_en  <= 1'b0;
      end else begin
         digit_num <= num_nxt;
         digit_sx  <= sx_nxt;
         digit_sy  <= BASE_Y;
         digit_en  <= en_nxt;
      end
   end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// Self-checking bench for score_digit_ctrl: table and slot probes go through
// an expected-value queue popped one cycle after each pixel is driven.
module tb_score_digit_ctrl;

   localparam logic [31:0] BX = 32'd20;
   localparam logic [31:0] BY = 32'd20;
   localparam logic [31:0] PT = 32'd60;

   logic        CLK = 1'b0;
   logic        RST;
   logic [13:0] score;
   logic        score_valid;
   logic        score_ready;
   logic        frame_start;
   logic [31:0] x;
   logic [31:0] y;
   logic [3:0]  digit_num;
   logic [31:0] digit_sx;
   logic [31:0] digit_sy;
   logic        digit_en;
   logic        ovf;

   typedef struct packed {
      logic [31:0] px;
      logic [31:0] py;
      logic [3:0]  num;
      logic [31:0] sx;
      logic        en;
   } pix_vec_t;

   pix_vec_t stim_q[$];
   pix_vec_t exp_q[$];
   pix_vec_t tbl_1234[12];

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   score_digit_ctrl #(.BASE_X(BX), .BASE_Y(BY), .PITCH(PT)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .score       (score),
      .score_valid (score_valid),
      .score_ready (score_ready),
      .frame_start (frame_start),
      .x           (x),
      .y           (y),
      .digit_num   (digit_num),
      .digit_sx    (digit_sx),
      .digit_sy    (digit_sy),
      .digit_en    (digit_en),
      .ovf         (ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [31:0] px, input logic [31:0] py,
                          input logic [3:0] num, input logic [31:0] sx, input logic en);
      pix_vec_t v;
      v.px = px; v.py = py; v.num = num; v.sx = sx; v.en = en;
      stim_q.push_back(v);
   endtask

   // One probe at the centre of each slot plus one far outside.
   task automatic add_slots(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3,
                            input logic [3:0] en_mask);
      add_vec(BX + 32'd25,          BY + 32'd45, d0, BX,          en_mask[0]);
      add_vec(BX + PT + 32'd25,     BY + 32'd45, d1, BX + PT,     en_mask[1]);
      add_vec(BX + 2*PT + 32'd25,   BY + 32'd45, d2, BX + 2*PT,   en_mask[2]);
      add_vec(BX + 3*PT + 32'd25,   BY + 32'd45, d3, BX + 3*PT,   en_mask[3]);
      add_vec(32'd0,                32'd0,       4'd0, BX,        1'b0);
   endtask

   task automatic cmp_pix(input pix_vec_t e);
      check($sformatf("num(%0d,%0d)", e.px, e.py), {28'd0, digit_num}, {28'd0, e.num});
      check($sformatf("sx(%0d,%0d)",  e.px, e.py), digit_sx, e.sx);
      check($sformatf("sy(%0d,%0d)",  e.px, e.py), digit_sy, BY);
      check($sformatf("en(%0d,%0d)",  e.px, e.py), {31'd0, digit_en}, {31'd0, e.en});
   endtask

   // Drive each queued pixel on a falling edge; the previous pixel's
   // expectation is popped and compared on that same falling edge.
   task automatic run_pix();
      pix_vec_t e;
      for (int i = 0; i < stim_q.size(); i++) begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_pix(e);
         end
         x = stim_q[i].px;
         y = stim_q[i].py;
         exp_q.push_back(stim_q[i]);
      end
      @(negedge CLK);
      e = exp_q.pop_front();
      cmp_pix(e);
      stim_q.delete();
   endtask

   // Offers a score on the next falling edge; returns one cycle after the
   // transfer edge with score_valid dropped.
   task automatic offer(input logic [13:0] s);
      @(negedge CLK);
      check("ready_before_offer", {31'd0, score_ready}, 32'd1);
      score       = s;
      score_valid = 1'b1;
      @(negedge CLK);
      score_valid = 1'b0;
   endtask

   task automatic pulse_frame();
      @(negedge CLK);
      frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
   endtask

   task automatic reset_pulse();
      #2 RST = 1'b1;
      #1;
      check("ready_in_reset", {31'd0, score_ready}, 32'd1);
      check("ovf_in_reset",   {31'd0, ovf},         32'd0);
      check("en_in_reset",    {31'd0, digit_en},    32'd0);
      check("sx_in_reset",    digit_sx,             BX);
      @(negedge CLK);
      RST = 1'b0;
      check("ready_after_reset", {31'd0, score_ready}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int low;

      // Display of 1234, including slot edges and gaps.
      tbl_1234[0]  = '{px: 32'd20,  py: 32'd20,  num: 4'd1, sx: 32'd20,  en: 1'b1};
      tbl_1234[1]  = '{px: 32'd69,  py: 32'd109, num: 4'd1, sx: 32'd20,  en: 1'b1};
      tbl_1234[2]  = '{px: 32'd70,  py: 32'd50,  num: 4'd0, sx: 32'd20,  en: 1'b0};
      tbl_1234[3]  = '{px: 32'd79,  py: 32'd50,  num: 4'd0, sx: 32'd20,  en: 1'b0};
      tbl_1234[4]  = '{px: 32'd80,  py: 32'd20,  num: 4'd2, sx: 32'd80,  en: 1'b1};
      tbl_1234[5]  = '{px: 32'd129, py: 32'd60,  num: 4'd2, sx: 32'd80,  en: 1'b1};
      tbl_1234[6]  = '{px: 32'd140, py: 32'd109, num: 4'd3, sx: 32'd140, en: 1'b1};
      tbl_1234[7]  = '{px: 32'd165, py: 32'd110, num: 4'd0, sx: 32'd20,  en: 1'b0};
      tbl_1234[8]  = '{px: 32'd200, py: 32'd50,  num: 4'd4, sx: 32'd200, en: 1'b1};
      tbl_1234[9]  = '{px: 32'd249, py: 32'd19,  num: 4'd0, sx: 32'd20,  en: 1'b0};
      tbl_1234[10] = '{px: 32'd249, py: 32'd20,  num: 4'd4, sx: 32'd200, en: 1'b1};
      tbl_1234[11] = '{px: 32'd250, py: 32'd50,  num: 4'd0, sx: 32'd20,  en: 1'b0};

      RST = 1'b1; score = '0; score_valid = 1'b0; frame_start = 1'b0;
      x = '0; y = '0;

      // Reset state.
      #12;
      check("rst_ready", {31'd0, score_ready}, 32'd1);
      check("rst_num",   {28'd0, digit_num},   32'd0);
      check("rst_sx",    digit_sx,             BX);
      check("rst_sy",    digit_sy,             BY);
      check("rst_en",    {31'd0, digit_en},    32'd0);
      check("rst_ovf",   {31'd0, ovf},         32'd0);
      @(negedge CLK);
      RST = 1'b0;

      // No score yet: frame pulses leave only the units slot visible as 0.
      pulse_frame(); pulse_frame(); pulse_frame();
      add_slots(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
      run_pix();

      // 1234: ready low for 15 cycles, display held until frame_start.
      offer(14'd1234);
      low = 0;
      for (int i = 1; i <= 15; i++) begin
         if (i > 1) @(negedge CLK);
         if (!score_ready) low++;
      end
      check("ready_low_cycles", low, 32'd15);
      add_slots(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
      run_pix();
      check("ready_pending", {31'd0, score_ready}, 32'd0);
      pulse_frame();
      check("ready_after_commit", {31'd0, score_ready}, 32'd1);
      for (int i = 0; i < 12; i++) stim_q.push_back(tbl_1234[i]);
      run_pix();

      // Saturation to 9999 with ovf, then a small score clears ovf.
      offer(14'd12000);
      check("ovf_set", {31'd0, ovf}, 32'd1);
      repeat (16) @(negedge CLK);
      pulse_frame();
      check("ovf_held", {31'd0, ovf}, 32'd1);
      add_slots(4'd9, 4'd9, 4'd9, 4'd9, 4'b1111);
      run_pix();
      offer(14'd5);
      check("ovf_clear", {31'd0, ovf}, 32'd0);
      repeat (16) @(negedge CLK);
      pulse_frame();
      add_slots(4'd0, 4'd0, 4'd0, 4'd5, 4'b1000);
      run_pix();

      // score_valid held with changing values: only 567 taken, then 890.
      @(negedge CLK);
      check("ready_hold_start", {31'd0, score_ready}, 32'd1);
      score = 14'd567; score_valid = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         @(negedge CLK);
         score = 14'd1000 + 14'(i * 37);
      end
      @(negedge CLK);
      score = 14'd890; frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
      check("ready_reopen", {31'd0, score_ready}, 32'd1);
      @(negedge CLK);
      check("second_taken", {31'd0, score_ready}, 32'd0);
      score_valid = 1'b0;
      add_slots(4'd0, 4'd5, 4'd6, 4'd7, 4'b1110);
      run_pix();
      repeat (16) @(negedge CLK);
      pulse_frame();
      add_slots(4'd0, 4'd8, 4'd9, 4'd0, 4'b1110);
      run_pix();

      // frame_start on the last conversion cycle must not commit.
      offer(14'd42);
      repeat (12) @(negedge CLK);
      @(negedge CLK);
      frame_start = 1'b1;
      @(negedge CLK);
      frame_start = 1'b0;
      check("no_early_commit", {31'd0, score_ready}, 32'd0);
      @(negedge CLK);
      check("still_pending", {31'd0, score_ready}, 32'd0);
      add_slots(4'd0, 4'd8, 4'd9, 4'd0, 4'b1110);
      run_pix();
      pulse_frame();
      check("ready_after_42", {31'd0, score_ready}, 32'd1);
      add_slots(4'd0, 4'd0, 4'd4, 4'd2, 4'b1100);
      run_pix();

      // Reset during PENDING clears ovf; reset mid-CONVERT of 4321 aborts.
      offer(14'd15000);
      check("ovf_15000", {31'd0, ovf}, 32'd1);
      repeat (18) @(negedge CLK);
      reset_pulse();
      offer(14'd4321);
      repeat (4) @(negedge CLK);
      reset_pulse();
      pulse_frame();
      check("ready_idle_frame", {31'd0, score_ready}, 32'd1);
      add_slots(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000);
      add_vec(BX + 32'd50, BY, 4'd0, BX, 1'b0);
      run_pix();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
